team_08_dino_draw: RTL and testbench
====================================

# team_08_dino_draw

Sprite renderer for the dino: the consumer end of the dino-motion handshake. It waits for `dinoMovement` and erases the sprite at the last drawn height. It then redraws the sprite at the current `dinoY`, streaming one pixel per transfer over a valid/ready pixel port to the display writer. It answers with a one-cycle `drawDoneDino`, which is what lets the jump logic drop `dinoMovement`.

## Interface
- `DINO_X`, 9'd20: screen column of the sprite's left edge.
- `DINO_W`, 16: sprite width in pixels (≤16).
- `DINO_H`, 16: sprite height in pixels (≤16).
- `BASE_Y`, 8'd220: screen row reference; sprite top row = `BASE_Y - dinoY` (8-bit wrap).
- `FLOOR_Y`, 8'd101: reset value of the last-drawn height.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `dinoY`  in  8  current dino height; a larger value is higher on screen.
- `dinoMovement`  in  1  level request: the sprite must be redrawn.
- `pix_ready`  in  1  display writer accepts the current pixel.
- `pix_valid`  out  1  pixel transfer pending.
- `pix_x`  out  9  pixel column.
- `pix_y`  out  8  pixel row.
- `pix_on`  out  1  1 = dino colour, 0 = background colour.
- `drawDoneDino`  out  1  one-cycle pulse when a full redraw is complete.

## Operation
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - `pix_valid`=0.
  - On `dinoMovement`=1: latch `newY` ← `dinoY`, clear `row`/`col`, go to ERASE.
- ERASE:
  - Scan the rectangle at `lastY` in row-major order, `row` 0..H-1 outer, `col` 0..W-1 inner.
  - `pix_x` = `DINO_X + col`, `pix_y` = `BASE_Y - lastY + row`, `pix_on`=0.
  - After the last transfer (row H-1, col W-1): clear counters, go to DRAW.
- DRAW:
  - Same scan at `newY`.
  - `pix_on` = SPRITE[row][W-1-col]. SPRITE is an internal constant bitmap of H rows × W bits; the MSB is the leftmost pixel.
  - After the last transfer: `lastY` ← `newY`, go to DONE.
- DONE: `drawDoneDino`=1 for exactly this cycle, then go to IDLE.
- The counters advance only on a transfer (`pix_valid && pix_ready`).
- While `pix_valid`=1 and `pix_ready`=0, `pix_x`/`pix_y`/`pix_on` hold stable.
- `pix_valid` is 1 in every ERASE/DRAW cycle and 0 in IDLE/DONE.
- `dinoY` changes during ERASE/DRAW are ignored; `newY` is latched once per redraw.
- `dinoMovement` is level-sampled only in IDLE. If it is still high in the IDLE cycle after DONE, a new redraw starts immediately.
- The erase and draw rectangles may overlap. Erase-then-draw ordering guarantees the final image is the sprite at `newY`.
- Arithmetic:
  - `pix_y` is computed modulo 256 and `pix_x` in 9 bits; no clamping.
  - Counters are `$clog2(W)`/`$clog2(H)` bits, minimum 1.
- Reset:
  - State=IDLE, counters=0, `lastY`=`FLOOR_Y`, `newY`=`FLOOR_Y`.
  - `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_on`=0, `drawDoneDino`=0.
  - Reset mid-redraw aborts immediately with no `drawDoneDino`. The next redraw erases at `FLOOR_Y`.

## Timing
- Request sampled at cycle t (IDLE, `dinoMovement`=1): the first ERASE pixel is valid at t+1.
- With `pix_ready` held at 1:
  - Erase transfers occupy t+1..t+W·H.
  - Draw transfers occupy t+W·H+1..t+2·W·H.
  - DONE (`drawDoneDino`=1) is at t+2·W·H+1. Defaults: 512 transfers, pulse at t+513.
- Each ready-low cycle adds exactly one cycle of latency.
- `drawDoneDino` is never high for more than one cycle and is never high while `pix_valid`=1.
- Back-to-back redraws: a new request is sampled in the IDLE cycle after DONE, and its first pixel is valid the cycle after that.

## Test plan
- Reset, then `dinoMovement`=1 with `dinoY`=101 and `pix_ready`=1.
  - Required: 256 transfers with `pix_on`=0 covering x 20..35, y 119..134.
  - Then 256 transfers matching SPRITE at the same rectangle.
  - `drawDoneDino` pulses at t+513.
- Second request with `dinoY`=121.
  - Required: the erase uses y 119..134 and the draw uses y 99..114.
  - `lastY` becomes 121, confirmed by a third redraw erasing at y 99..114.
- Random `pix_ready` backpressure (about 50% low).
  - Required: outputs stay stable while stalled.
  - Exactly 512 transfers in scan order; the pulse lands 1 cycle after the last transfer.
- `dinoY` toggled every cycle during a redraw.
  - Required: every DRAW pixel uses the value latched at start. `dinoMovement` held high through DONE triggers an immediate second redraw starting the next IDLE cycle.
- `rst` asserted at transfer 300.
  - Required: next cycle `pix_valid`=0 and no `drawDoneDino`.
  - The next request erases at y 119..134 (`FLOOR_Y`).
- `dinoY`=230.
  - Required: the sprite top row wraps to y 246 (220-230 mod 256) and the rows continue 246..255, 0..5 with no stall or error.

Source files
------------

// File: rtl/team_08_dino_draw.sv
// rtl/team_08_dino_draw.sv - dino sprite erase/redraw engine streaming pixels over a valid/ready port
// Outputs are registered from the next-state values so the first pixel appears one cycle after the request.
module team_08_dino_draw #(
    parameter logic [8:0] DINO_X  = 9'd20,
    parameter int         DINO_W  = 16,
    parameter int         DINO_H  = 16,
    parameter logic [7:0] BASE_Y  = 8'd220,
    parameter logic [7:0] FLOOR_Y = 8'd101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dinoY,
    input  logic       dinoMovement,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic       pix_on,
    output logic       drawDoneDino
);
    localparam int CW = (DINO_W > 1) ? $clog2(DINO_W) : 1;
    localparam int RW = (DINO_H > 1) ? $clog2(DINO_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(DINO_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DINO_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    new_y_q, new_y_d, last_y_q, last_y_d;
    logic          pix_valid_q, pix_valid_d, pix_on_q, pix_on_d, done_q, done_d;
    logic [8:0]    pix_x_q, pix_x_d;
    logic [7:0]    pix_y_q, pix_y_d, scan_y;
    logic [15:0]   row_bits;
    logic [3:0]    bit_idx;
    logic          xfer, scan_last;

    // MSB of each row is the leftmost pixel
    function automatic logic [15:0] sprite_row(input logic [RW-1:0] r);
        case (4'(r))
            4'd0:  sprite_row = 16'h01FE;
            4'd1:  sprite_row = 16'h037F;
            4'd2:  sprite_row = 16'h03FF;
            4'd3:  sprite_row = 16'h03FF;
            4'd4:  sprite_row = 16'h03E0;
            4'd5:  sprite_row = 16'h03FC;
            4'd6:  sprite_row = 16'h87C0;
            4'd7:  sprite_row = 16'hCFF0;
            4'd8:  sprite_row = 16'hFFD0;
            4'd9:  sprite_row = 16'hFFC0;
            4'd10: sprite_row = 16'h7FC0;
            4'd11: sprite_row = 16'h3F80;
            4'd12: sprite_row = 16'h1F00;
            4'd13: sprite_row = 16'h1980;
            4'd14: sprite_row = 16'h1080;
            4'd15: sprite_row = 16'h18C0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        new_y_d   = new_y_q;
        last_y_d  = last_y_q;
        xfer      = pix_valid_q && pix_ready;
        scan_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
        case (state_q)
            S_IDLE: begin
                if (dinoMovement) begin
                    new_y_d = dinoY;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_ERASE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (scan_last) begin
                        if (state_q == S_ERASE) begin
                            state_d = S_DRAW;
                        end else begin
                            state_d  = S_DONE;
                            last_y_d = new_y_q;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Derive the pixel from the next counters so a stall recomputes the same value
        row_bits    = sprite_row(row_d);
        bit_idx     = 4'(DINO_W - 1) - 4'(col_d);
        pix_valid_d = (state_d == S_ERASE) || (state_d == S_DRAW);
        scan_y      = (state_d == S_DRAW) ? new_y_d : last_y_d;
        pix_x_d     = pix_valid_d ? DINO_X + 9'(col_d) : 9'd0;
        pix_y_d     = pix_valid_d ? BASE_Y - scan_y + 8'(row_d) : 8'd0;
        pix_on_d    = (state_d == S_DRAW) && row_bits[bit_idx];
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            new_y_q     <= FLOOR_Y;
            last_y_q    <= FLOOR_Y;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_on_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            new_y_q     <= new_y_d;
            last_y_q    <= last_y_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_on_q    <= pix_on_d;
            done_q      <= done_d;
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_on       = pix_on_q;
    assign drawDoneDino = done_q;
endmodule

// File: tb/tb_team_08_dino_draw.sv
// tb/tb_team_08_dino_draw.sv - randomized self-checking bench for team_08_dino_draw
module tb_team_08_dino_draw;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dinoY = 8'd0;
    logic       dinoMovement = 1'b0;
    logic       pix_ready = 1'b1;
    logic       pix_valid, pix_on, drawDoneDino;
    logic [8:0] pix_x;
    logic [7:0] pix_y;

    team_08_dino_draw dut (
        .clk(clk), .rst(rst), .dinoY(dinoY), .dinoMovement(dinoMovement),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_on(pix_on), .drawDoneDino(drawDoneDino)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] SPR [16] = '{
        16'h01FE, 16'h037F, 16'h03FF, 16'h03FF, 16'h03E0, 16'h03FC, 16'h87C0, 16'hCFF0,
        16'hFFD0, 16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00, 16'h1980, 16'h1080, 16'h18C0};

    typedef struct {
        int x;
        int y;
        int on;
    } pix_t;

    int   checks = 0;
    int   failures = 0;
    pix_t q[$];
    int   phase = 0;
    int   model_last_y = 101;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   done_count = 0;
    int   xfer_idx = 0;
    int   first_y_erase = 0;
    int   first_y_draw = 0;
    int   last_y_draw = 0;
    bit   rand_ready = 0;
    bit   toggle_y = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a redraw is a list of 512 pixels, erase rectangle then sprite
    always @(negedge clk) begin
        pix_t e;
        cyc++;
        chk("pix_valid", {31'd0, pix_valid}, {31'd0, phase == 1});
        chk("drawDoneDino", {31'd0, drawDoneDino}, {31'd0, phase == 2});
        if (drawDoneDino) begin
            done_count++;
            done_cyc = cyc;
        end
        if (phase == 1 && q.size() > 0) begin
            e = q[0];
            chk("pix_x", {23'd0, pix_x}, e.x);
            chk("pix_y", {24'd0, pix_y}, e.y);
            chk("pix_on", {31'd0, pix_on}, e.on);
        end
        if (rst) begin
            phase = 0;
            q.delete();
            model_last_y = 101;
        end else if (phase == 1) begin
            if (pix_ready) begin
                if (xfer_idx == 0) first_y_erase = pix_y;
                if (xfer_idx == 256) first_y_draw = pix_y;
                if (xfer_idx == 511) last_y_draw = pix_y;
                xfer_idx++;
                void'(q.pop_front());
                if (q.size() == 0) phase = 2;
            end
        end else if (phase == 2) begin
            phase = 0;
        end else if (dinoMovement) begin
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    q.push_back('{20 + c, (220 - model_last_y + r) & 255, 0});
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    q.push_back('{20 + c, (220 - int'(dinoY) + r) & 255, int'(SPR[r][15 - c])});
            model_last_y = dinoY;
            xfer_idx = 0;
            start_cyc = cyc;
            phase = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (toggle_y) dinoY = 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        int start = done_count;
        int n = 0;
        while (done_count == start && n < 3000) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, {31'd0, done_count == start}, 32'd0);
    endtask

    task automatic redraw(input int y, input string name);
        dinoY = 8'(y);
        dinoMovement = 1'b1;
        step();
        dinoMovement = 1'b0;
        wait_done(name);
        step();
    endtask

    initial begin
        int saved_done;
        repeat (3) step();
        chk("reset_valid", {31'd0, pix_valid}, 32'd0);
        chk("reset_x", {23'd0, pix_x}, 32'd0);
        chk("reset_y", {24'd0, pix_y}, 32'd0);
        chk("reset_on", {31'd0, pix_on}, 32'd0);
        chk("reset_done", {31'd0, drawDoneDino}, 32'd0);
        rst = 1'b0;
        step();

        redraw(101, "first");
        chk("first_erase_y", first_y_erase, 119);
        chk("first_draw_y", first_y_draw, 119);
        chk("first_last_y", last_y_draw, 134);
        chk("first_latency", done_cyc - start_cyc, 513);

        redraw(121, "second");
        chk("second_erase_y", first_y_erase, 119);
        chk("second_draw_y", first_y_draw, 99);

        rand_ready = 1;
        redraw(60, "backpressure");
        chk("bp_erase_y", first_y_erase, 99);
        chk("bp_xfers", xfer_idx, 512);
        chk("bp_draw_y", first_y_draw, 160);

        dinoY = 8'd80;
        dinoMovement = 1'b1;
        step();
        toggle_y = 1;
        wait_done("toggle");
        toggle_y = 0;
        saved_done = done_cyc;
        dinoY = 8'd90;
        chk("toggle_draw_y", first_y_draw, 140);
        step();
        dinoMovement = 1'b0;
        wait_done("back_to_back");
        chk("b2b_start", start_cyc - saved_done, 1);
        chk("b2b_erase_y", first_y_erase, 140);
        chk("b2b_draw_y", first_y_draw, 130);
        step();

        dinoY = 8'd70;
        dinoMovement = 1'b1;
        step();
        dinoMovement = 1'b0;
        for (int n = 0; n < 3000 && xfer_idx < 300; n++) step();
        saved_done = done_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("abort_valid", {31'd0, pix_valid}, 32'd0);
        chk("abort_no_done", done_count, saved_done);

        redraw(101, "after_reset");
        chk("after_reset_erase_y", first_y_erase, 119);

        rand_ready = 0;
        redraw(230, "wrap");
        chk("wrap_top_y", first_y_draw, 246);
        chk("wrap_bottom_y", last_y_draw, 5);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
